vote_tally: RTL and testbench

VOTE_TALLY -- requirements
Module: vote_tally

---
 rtl/voter_pkg.sv | 17 +
 rtl/tally_counter.sv | 27 ++
 rtl/vote_tally.sv | 134 +++++++++++++
 tb/tb_vote_tally.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/voter_pkg.sv
// Shared definitions for the ballot tally block: session state encoding,
// candidate count, default counter width and the "no winner" code.
package voter_pkg;

  localparam int NCAND     = 3;
  localparam int CNT_W_DEF = 8;

  localparam logic [1:0] WINNER_NONE = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPEN = 2'd1,
    ST_EVAL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/tally_counter.sv
// Saturating up-counter with synchronous clear; cnt updates the edge after inc.
// sat flags an increment that was dropped because the counter is already full.
module tally_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic full;

  assign full = &cnt;
  assign sat  = inc & full;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !full) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vote_tally.sv
// Session-based ballot tally: counts one-hot ballots per candidate, picks a winner on close.
// Ballots accepted only while OPEN; result_valid rises two edges after close_i is launched.
module vote_tally
  import voter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NCAND = voter_pkg::NCAND
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             open_i,
  input  logic             close_i,
  input  logic             ballot_valid,
  input  logic [NCAND-1:0] ballot,
  output logic             ballot_ready,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3,
  output logic [CNT_W-1:0] invalid_cnt,
  output logic [1:0]       winner,
  output logic             result_valid,
  output logic             overflow,
  output logic [1:0]       state
);

  state_t           state_q;
  state_t           state_d;
  logic             clr;
  logic             accept;
  logic             one_hot;
  logic [NCAND-1:0] cand_inc;
  logic             inv_inc;
  logic [NCAND:0]   sat;
  logic [CNT_W-1:0] cand_cnt [NCAND];

  // Ties for the maximum (including the all-zero case) yield no winner.
  function automatic logic [1:0] pick_winner(input logic [CNT_W-1:0] a,
                                             input logic [CNT_W-1:0] b,
                                             input logic [CNT_W-1:0] c);
    if (a > b && a > c) return 2'd1;
    if (b > a && b > c) return 2'd2;
    if (c > a && c > b) return 2'd3;
    return WINNER_NONE;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (open_i) begin
          clr     = 1'b1;
          state_d = ST_OPEN;
        end
      end
      ST_OPEN: begin
        if (close_i) state_d = ST_EVAL;
      end
      ST_EVAL: state_d = ST_DONE;
      ST_DONE: begin
        if (open_i) begin
          clr     = 1'b1;
          state_d = ST_OPEN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ballot_ready = (state_q == ST_OPEN);
  assign accept       = ballot_valid & ballot_ready;
  assign one_hot      = ($countones(ballot) == 1);
  assign cand_inc     = (accept && one_hot) ? ballot : '0;
  assign inv_inc      = accept & ~one_hot;

  for (genvar k = 0; k < NCAND; k++) begin : g_cand
    tally_counter #(.W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (cand_inc[k]),
      .cnt (cand_cnt[k]),
      .sat (sat[k])
    );
  end

  tally_counter #(.W(CNT_W)) u_invalid (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (inv_inc),
    .cnt (invalid_cnt),
    .sat (sat[NCAND])
  );

  assign cnt1  = cand_cnt[0];
  assign cnt2  = cand_cnt[1];
  assign cnt3  = cand_cnt[2];
  assign state = state_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      overflow <= 1'b0;
    end else if (|sat) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      winner <= WINNER_NONE;
    end else if (state_q == ST_EVAL) begin
      winner <= pick_winner(cand_cnt[0], cand_cnt[1], cand_cnt[2]);
    end
  end

  // Tracks the next state so the flag is high for every cycle spent in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_valid <= 1'b0;
    end else begin
      result_valid <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_vote_tally.sv
// Bench for vote_tally: directed vector table, a saturation sequence, then random
// sessions compared against a count-based reference model.
module tb_vote_tally;

  localparam int CNT_W = 4;
  localparam int MAXV  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             open_i = 1'b0;
  logic             close_i = 1'b0;
  logic             ballot_valid = 1'b0;
  logic [2:0]       ballot = 3'b000;
  logic             ballot_ready;
  logic [CNT_W-1:0] cnt1, cnt2, cnt3, invalid_cnt;
  logic [1:0]       winner;
  logic             result_valid;
  logic             overflow;
  logic [1:0]       state;

  int checks = 0;
  int errors = 0;

  vote_tally #(.CNT_W(CNT_W), .NCAND(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .open_i       (open_i),
    .close_i      (close_i),
    .ballot_valid (ballot_valid),
    .ballot       (ballot),
    .ballot_ready (ballot_ready),
    .cnt1         (cnt1),
    .cnt2         (cnt2),
    .cnt3         (cnt3),
    .invalid_cnt  (invalid_cnt),
    .winner       (winner),
    .result_valid (result_valid),
    .overflow     (overflow),
    .state        (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         r, o, c, v;
    logic [2:0] b;
    int         st, c1, c2, c3, inv, win, rv, ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit o, bit c, bit v, logic [2:0] b,
                              int st, int c1, int c2, int c3, int inv,
                              int win, int rv, int ovf);
    vec_t t;
    t.r = r; t.o = o; t.c = c; t.v = v; t.b = b;
    t.st = st; t.c1 = c1; t.c2 = c2; t.c3 = c3; t.inv = inv;
    t.win = win; t.rv = rv; t.ovf = ovf;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int st, input int c1, input int c2,
                           input int c3, input int inv, input int win, input int rv,
                           input int ovf);
    chk({tag, ".state"}, int'(state), st);
    chk({tag, ".ballot_ready"}, int'(ballot_ready), (st == 1) ? 1 : 0);
    chk({tag, ".cnt1"}, int'(cnt1), c1);
    chk({tag, ".cnt2"}, int'(cnt2), c2);
    chk({tag, ".cnt3"}, int'(cnt3), c3);
    chk({tag, ".invalid_cnt"}, int'(invalid_cnt), inv);
    chk({tag, ".winner"}, int'(winner), win);
    chk({tag, ".result_valid"}, int'(result_valid), rv);
    chk({tag, ".overflow"}, int'(overflow), ovf);
  endtask

  // Drive one cycle of inputs, then settle just past the sampling edge.
  task automatic apply(input bit r, input bit o, input bit c, input bit v, input logic [2:0] b);
    rst = r; open_i = o; close_i = c; ballot_valid = v; ballot = b;
    @(posedge clk);
    #1;
  endtask

  // Reference model: per-candidate totals, phase number, sticky overflow, winner.
  int m_cnt[4];
  int m_phase;
  int m_win;
  int m_ovf;

  task automatic m_clear();
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    m_ovf = 0;
    m_win = 0;
  endtask

  function automatic int winner_of();
    int best = 0;
    int nbest = 0;
    int who = 0;
    for (int k = 0; k < 3; k++) begin
      if (m_cnt[k] > best) begin
        best = m_cnt[k]; nbest = 1; who = k + 1;
      end else if (m_cnt[k] == best) begin
        nbest++;
      end
    end
    if (best == 0 || nbest != 1) return 0;
    return who;
  endfunction

  task automatic model_step(input bit r, input bit o, input bit c, input bit v, input logic [2:0] b);
    int idx;
    if (r) begin
      m_clear();
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (o) begin m_clear(); m_phase = 1; end
        1: begin
          if (v) begin
            idx = (b == 3'b001) ? 0 : (b == 3'b010) ? 1 : (b == 3'b100) ? 2 : 3;
            if (m_cnt[idx] == MAXV) m_ovf = 1;
            else m_cnt[idx] = m_cnt[idx] + 1;
          end
          if (c) m_phase = 2;
        end
        2: begin m_win = winner_of(); m_phase = 3; end
        default: if (o) begin m_clear(); m_phase = 1; end
      endcase
    end
  endtask

  initial begin
    //            r o c v  b       st c1 c2 c3 inv win rv ovf
    vecs.push_back(mk(1,0,0,0,3'b000, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1,0,0,1,3'b001, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,0,0,1,3'b001, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,0,1,0,3'b000, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,1,0,0,3'b000, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,0,0,1,3'b001, 1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,0,0,1,3'b010, 1, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,0,0,1,3'b001, 1, 2, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,0,0,1,3'b100, 1, 2, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0,0,0,1,3'b001, 1, 3, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0,0,1,0,3'b000, 2, 3, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0,0,0,1,3'b001, 3, 3, 1, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0,1,0,1,3'b010, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,0,0,1,3'b011, 1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0,0,0,1,3'b000, 1, 0, 0, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0,0,0,1,3'b010, 1, 0, 1, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0,0,0,1,3'b100, 1, 0, 1, 1, 2, 0, 0, 0));
    vecs.push_back(mk(0,0,1,0,3'b000, 2, 0, 1, 1, 2, 0, 0, 0));
    vecs.push_back(mk(0,0,0,0,3'b000, 3, 0, 1, 1, 2, 0, 1, 0));
    vecs.push_back(mk(0,1,0,0,3'b000, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,0,1,1,3'b100, 2, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0,0,0,1,3'b001, 3, 0, 0, 1, 0, 3, 1, 0));
    vecs.push_back(mk(0,1,1,0,3'b000, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,1,1,1,3'b001, 2, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,0,0,0,3'b000, 3, 1, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0,1,0,0,3'b000, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,0,0,1,3'b001, 1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,0,0,1,3'b010, 1, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,0,0,1,3'b100, 1, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1,1,0,1,3'b001, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,1,0,0,3'b000, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,0,1,0,3'b000, 2, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,0,0,0,3'b000, 3, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1,0,0,0,3'b000, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].r, vecs[i].o, vecs[i].c, vecs[i].v, vecs[i].b);
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].c1, vecs[i].c2, vecs[i].c3,
                vecs[i].inv, vecs[i].win, vecs[i].rv, vecs[i].ovf);
    end

    // Saturation: 17 votes for candidate 2 into a 4-bit counter.
    apply(0, 1, 0, 0, 3'b000);
    check_all("sat_open", 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 17; i++) begin
      apply(0, 0, 0, 1, 3'b010);
      chk($sformatf("sat%0d.cnt2", i), int'(cnt2), (i > MAXV) ? MAXV : i);
      chk($sformatf("sat%0d.overflow", i), int'(overflow), (i > MAXV) ? 1 : 0);
    end
    apply(0, 0, 1, 0, 3'b000);
    check_all("sat_eval", 2, 0, 15, 0, 0, 0, 0, 1);
    apply(0, 0, 0, 0, 3'b000);
    check_all("sat_done", 3, 0, 15, 0, 0, 2, 1, 1);
    apply(0, 1, 0, 0, 3'b000);
    check_all("sat_reopen", 1, 0, 0, 0, 0, 0, 0, 0);

    // Random sessions against the reference model.
    apply(1, 0, 0, 0, 3'b000);
    model_step(1, 0, 0, 0, 3'b000);
    for (int i = 0; i < 3000; i++) begin
      bit r, o, c, v;
      logic [2:0] b;
      r = ($urandom_range(0, 99) < 2);
      o = ($urandom_range(0, 99) < 8);
      c = ($urandom_range(0, 99) < 5);
      v = ($urandom_range(0, 99) < 75);
      b = 3'($urandom_range(0, 7));
      apply(r, o, c, v, b);
      model_step(r, o, c, v, b);
      check_all($sformatf("rnd%0d", i), m_phase, m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3],
                m_win, (m_phase == 3) ? 1 : 0, m_ovf);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
